// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(15,11) arbitrated encoder.
//   DATA_W / CODE_W / PAR_W : data, codeword and parity widths
//   data_t / code_t         : data word and codeword types
//   state_e                 : output-stage occupancy (ST_EMPTY / ST_FULL)
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 15;
  localparam int PAR_W  = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

endpackage

// File: rtl/hamming_enc_15_11.sv
// Combinational Hamming(15,11) encoder, even parity.
//   data_i : D1..D11 at bits 0..10
//   code_o : codeword, bit n-1 holds position n
//            (P1,P2,D1,P4,D2,D3,D4,P8,D5..D11 at positions 1..15)
module hamming_enc_15_11
  import hamming_pkg::*;
(
  input  data_t data_i,
  output code_t code_o
);

  code_t code_v;
  logic  par_v;
  int    di;

  always_comb begin
    code_v = '0;
    par_v  = 1'b0;
    di     = 0;
    // Data bits fill every position that is not a power of two, in order.
    for (int pos = 1; pos <= CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        code_v[pos-1] = data_i[di];
        di = di + 1;
      end
    end
    // Parity Pk covers every position whose index has bit k set. Parity
    // positions never fall inside another parity group's earlier-set bits,
    // so computing them in place on the partly built word is safe.
    for (int k = 0; k < PAR_W; k++) begin
      par_v = 1'b0;
      for (int pos = 1; pos <= CODE_W; pos++) begin
        if ((pos & (1 << k)) != 0) par_v = par_v ^ code_v[pos-1];
      end
      code_v[(1 << k) - 1] = par_v;
    end
  end

  assign code_o = code_v;

endmodule

// File: rtl/hamming_enc_arb.sv
// Two-requester round-robin arbiter feeding a Hamming(15,11) encoder with a
// one-entry output register (same-cycle drain and refill supported).
//   clk, rst_n                : clock, asynchronous active-low reset
//   reqN_valid/data/ready     : requester handshakes (N = 0,1)
//   out_valid/ready/code/src  : codeword output handshake and source index
//   enc_count                 : delivered-codeword counter, present only when
//                               HAMMING_ENC_ARB_STATS_EN is defined
module hamming_enc_arb
  import hamming_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int NUM_REQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [10:0]       req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [10:0]       req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [14:0]       out_code,
  output logic              out_src
`ifdef HAMMING_ENC_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  enc_count
`endif
);

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  code_t              code_q, code_d;
  logic               src_q, src_d;
  logic [NUM_REQ-1:0] req_vld;
  logic [NUM_REQ-1:0] gnt;
  logic               can_load;
  logic               xfer_in;
  data_t              sel_data;
  code_t              enc_code;

  assign req_vld  = {req1_valid, req0_valid};
  assign can_load = (state_q == ST_EMPTY) || out_ready;

  // Grant depends only on valids, occupancy, out_ready and the pointer.
  // Gating with rst_n keeps both readys low while reset is held.
  always_comb begin
    gnt = '0;
    if (rst_n && can_load) begin
      if (&req_vld) gnt[prio_q] = 1'b1;
      else          gnt         = req_vld;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign xfer_in    = |gnt;
  assign sel_data   = gnt[1] ? req1_data : req0_data;

  hamming_enc_15_11 u_enc (
    .data_i (sel_data),
    .code_o (enc_code)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    code_d  = code_q;
    src_d   = src_q;
    if (xfer_in) begin
      state_d = ST_FULL;
      prio_d  = ~gnt[1];  // favour the requester that just lost
      code_d  = enc_code;
      src_d   = gnt[1];
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      prio_q  <= 1'b0;
      code_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      code_q  <= code_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_code  = code_q;
  assign out_src   = src_q;

`ifdef HAMMING_ENC_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wraps naturally from all-ones to zero.
  assign cnt_d = (out_valid && out_ready) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign enc_count = cnt_q;
`endif

endmodule
